// File: rtl/throw_judge.sv
// rtl/throw_judge.sv - judges a bowling throw against the target lane, tracks the frame
//
// Purpose: accepts a throw (x_pos, pow_lvl, target) over a valid/ready handshake,
// models ball travel for TRAVEL_CYCLES clocks, then emits one-cycle hit/miss pulses
// with pin count, strike/spare and frame-end flags.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   throw_valid/ready     throw handshake; ready only while idle
//   x_pos, pow_lvl,target throw parameters, sampled on accept
//   round_reset           synchronous frame clear; aborts an in-flight throw
//   hit, miss             one-cycle judgement pulses (exactly one per throw)
//   pins_down             pins knocked by the last judged throw (held)
//   pins_standing         pins left in the current frame
//   roll_idx              0 = first roll, 1 = second roll
//   strike, spare         one-cycle pulses coincident with hit
//   frame_done            one-cycle pulse coincident with hit/miss at frame end
//   gutter                one-cycle pulse with miss on an edge throw
//
// Optional feature: define GUTTER_DETECT_EN to force a miss for x_pos 0 or 15
// and pulse gutter; otherwise gutter stays 0 and edges use the normal lane rule.

module throw_judge #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int PINS          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       throw_valid,
  output logic       throw_ready,
  input  logic [3:0] x_pos,
  input  logic [2:0] pow_lvl,
  input  logic [2:0] target,
  input  logic       round_reset,
  output logic       hit,
  output logic       miss,
  output logic [3:0] pins_down,
  output logic [3:0] pins_standing,
  output logic       roll_idx,
  output logic       strike,
  output logic       spare,
  output logic       frame_done,
  output logic       gutter
);

  typedef enum logic [1:0] {IDLE, TRAVEL, JUDGE} state_t;

  localparam logic [3:0] PINS_L  = 4'(PINS);
  localparam logic [7:0] CNT_LD  = 8'(TRAVEL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] x_q, x_d;
  logic [2:0] pow_q, pow_d;
  logic [2:0] tgt_q, tgt_d;
  logic       ready_q, ready_d;
  logic       hit_q, hit_d, miss_q, miss_d;
  logic       strike_q, strike_d, spare_q, spare_d;
  logic       fd_q, fd_d, gutter_q, gutter_d;
  logic [3:0] down_q, down_d;
  logic [3:0] stand_q, stand_d;
  logic       roll_q, roll_d;

  logic [2:0] lane;
  logic       is_gutter;
  logic       judged_hit;
  logic [4:0] reach;
  logic [3:0] knocked;
  logic [3:0] remain;

`ifdef GUTTER_DETECT_EN
  assign is_gutter = (x_q == 4'd0) || (x_q == 4'd15);
`else
  // Only the lane bits matter when edge detection is compiled out.
  logic unused_x;
  assign unused_x  = ^x_q[1:0];
  assign is_gutter = 1'b0;
`endif

  always_comb begin
    lane       = {1'b0, x_q[3:2]} + 3'd1;
    judged_hit = (lane == tgt_q) && (pow_q != 3'd0) &&
                 (tgt_q >= 3'd1) && (tgt_q <= 3'd4) && !is_gutter;
    // Reach can exceed the rack (up to 16), so clamp to what is standing.
    reach      = {1'b0, pow_q, 1'b0} + 5'd2;
    if (!judged_hit)
      knocked = 4'd0;
    else if (reach > {1'b0, stand_q})
      knocked = stand_q;
    else
      knocked = reach[3:0];
    remain = stand_q - knocked;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    pow_d    = pow_q;
    tgt_d    = tgt_q;
    down_d   = down_q;
    stand_d  = stand_q;
    roll_d   = roll_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    strike_d = 1'b0;
    spare_d  = 1'b0;
    fd_d     = 1'b0;
    gutter_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (throw_valid && !round_reset) begin
          x_d     = x_pos;
          pow_d   = pow_lvl;
          tgt_d   = target;
          cnt_d   = CNT_LD;
          state_d = TRAVEL;
        end
      end
      TRAVEL: begin
        if (cnt_q == 8'd0) state_d = JUDGE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      JUDGE: begin
        hit_d    = judged_hit;
        miss_d   = !judged_hit;
        gutter_d = is_gutter;
        down_d   = knocked;
        if (!roll_q) begin
          if (knocked == PINS_L) begin
            strike_d = 1'b1;
            fd_d     = 1'b1;
            stand_d  = PINS_L;
          end else begin
            stand_d = remain;
            roll_d  = 1'b1;
          end
        end else begin
          fd_d    = 1'b1;
          spare_d = (remain == 4'd0) && (knocked != 4'd0);
          stand_d = PINS_L;
          roll_d  = 1'b0;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Frame clear wins over any judgement in progress.
    if (round_reset) begin
      state_d  = IDLE;
      stand_d  = PINS_L;
      roll_d   = 1'b0;
      down_d   = down_q;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      strike_d = 1'b0;
      spare_d  = 1'b0;
      fd_d     = 1'b0;
      gutter_d = 1'b0;
    end

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      x_q      <= 4'd0;
      pow_q    <= 3'd0;
      tgt_q    <= 3'd0;
      ready_q  <= 1'b1;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      strike_q <= 1'b0;
      spare_q  <= 1'b0;
      fd_q     <= 1'b0;
      gutter_q <= 1'b0;
      down_q   <= 4'd0;
      stand_q  <= PINS_L;
      roll_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      pow_q    <= pow_d;
      tgt_q    <= tgt_d;
      ready_q  <= ready_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      strike_q <= strike_d;
      spare_q  <= spare_d;
      fd_q     <= fd_d;
      gutter_q <= gutter_d;
      down_q   <= down_d;
      stand_q  <= stand_d;
      roll_q   <= roll_d;
    end
  end

  assign throw_ready   = ready_q;
  assign hit           = hit_q;
  assign miss          = miss_q;
  assign strike        = strike_q;
  assign spare         = spare_q;
  assign frame_done    = fd_q;
  assign gutter        = gutter_q;
  assign pins_down     = down_q;
  assign pins_standing = stand_q;
  assign roll_idx      = roll_q;

endmodule
